// File: rtl/demux_route_pkg.sv
// Shared types and constants for the demux routing controller.
package demux_route_pkg;

  // Controller state, 2-bit encoding
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } route_state_t;

  // Destination channel codes: {s1, s2} selects demux output y_(code+1)
  localparam logic [1:0] CH_Y1 = 2'd0;
  localparam logic [1:0] CH_Y2 = 2'd1;
  localparam logic [1:0] CH_Y3 = 2'd2;
  localparam logic [1:0] CH_Y4 = 2'd3;

  // Parameter defaults
  localparam int DEF_WIDTH      = 8;
  localparam int DEF_GAP_CYCLES = 1;

  // Gap counter is fixed at 4 bits, enough for up to 15 idle cycles
  localparam int GAP_CNT_W = 4;

  // Reload value for the gap counter; counts down to zero inclusive
  function automatic logic [GAP_CNT_W-1:0] gap_reload(input int gap_cycles);
    return GAP_CNT_W'(gap_cycles - 1);
  endfunction

endpackage

// File: rtl/demux_route_ctrl_shift_reg.sv
// MSB-first parallel-load shift register feeding the serial demux input.
// Zeros are shifted in from the LSB side, so once a full word has been
// shifted out the MSB reads 0 without any extra gating.
module route_shift_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] din,
  output logic             msb
);

  logic [WIDTH-1:0] sr;

  // Clear has priority, then parallel load, then shift-left
  always_ff @(posedge clk) begin
    if (clr) begin
      sr <= '0;
    end else if (load) begin
      sr <= din;
    end else if (shift) begin
      sr <= {sr[WIDTH-2:0], 1'b0};
    end
  end

  assign msb = sr[WIDTH-1];

endmodule

// File: rtl/demux_route_ctrl.sv
// Routing controller ahead of the 1x4 demux tree: accepts a word plus a
// 2-bit destination, holds the demux selects for the whole frame, shifts
// the word out MSB-first and then idles for a fixed gap before the next.
module demux_route_ctrl
  import demux_route_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int GAP_CYCLES = DEF_GAP_CYCLES
) (
  input  logic             in_clk,
  input  logic             in_rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_dest,
  output logic             out_ready,
  output logic             out_ser,
  output logic             out_s1,
  output logic             out_s2,
  output logic             out_frame,
  output logic             out_last
);

  localparam int                   CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0]     BIT_LOAD = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0]     BIT_ONE  = CNT_W'(1);
  localparam logic [GAP_CNT_W-1:0] GAP_LOAD = gap_reload(GAP_CYCLES);
  localparam logic [GAP_CNT_W-1:0] GAP_ONE  = GAP_CNT_W'(1);
  localparam bit                   HAS_GAP  = (GAP_CYCLES != 0);

  route_state_t         state;
  logic [CNT_W-1:0]     bit_cnt;
  logic [GAP_CNT_W-1:0] gap_cnt;
  logic                 sel_s1;
  logic                 sel_s2;
  logic                 frame_q;
  logic                 last_q;
  logic                 accept;
  logic                 sr_shift;
  logic                 sr_msb;

  // A word is taken only in IDLE; inputs are don't-care elsewhere
  assign accept   = (state == IDLE) && in_valid;
  assign sr_shift = (state == SHIFT);

  route_shift_reg #(
    .WIDTH (WIDTH)
  ) u_shift (
    .clk   (in_clk),
    .clr   (in_rst),
    .load  (accept),
    .shift (sr_shift),
    .din   (in_data),
    .msb   (sr_msb)
  );

  // Control FSM with counters, select register and registered frame flags
  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      state   <= IDLE;
      bit_cnt <= '0;
      gap_cnt <= '0;
      sel_s1  <= 1'b0;
      sel_s2  <= 1'b0;
      frame_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            bit_cnt <= BIT_LOAD;
            sel_s1  <= in_dest[1];
            sel_s2  <= in_dest[0];
            frame_q <= 1'b1;
            last_q  <= 1'b0;
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          if (bit_cnt == '0) begin
            frame_q <= 1'b0;
            last_q  <= 1'b0;
            if (HAS_GAP) begin
              gap_cnt <= GAP_LOAD;
              state   <= GAP;
            end else begin
              state   <= IDLE;
            end
          end else begin
            bit_cnt <= bit_cnt - BIT_ONE;
            // The bit presented next cycle is the LSB when one step remains
            last_q  <= (bit_cnt == BIT_ONE);
          end
        end
        GAP: begin
          if (gap_cnt == '0) begin
            state <= IDLE;
          end else begin
            gap_cnt <= gap_cnt - GAP_ONE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Selects stay on the last captured destination until the next capture
  assign out_ready = (state == IDLE);
  assign out_ser   = sr_msb;
  assign out_s1    = sel_s1;
  assign out_s2    = sel_s2;
  assign out_frame = frame_q;
  assign out_last  = last_q;

endmodule
